nexys4_input_ctrl: RTL and testbench

Input controller between the Nexys4 board pins and the SoC's CPU-facing peripheral logic. It synchronises and debounces the two push buttons. On a debounced press of button 0 it captures the 16 slide switches into a holding register and offers that value to the CPU over a ready/ack handshake. A debounced press of button 1 raises a separate request flag, and an overrun flag records button-0 presses lost while captured data was still unread.

---
 rtl/nexys4_input_ctrl_pkg.sv | 16 +
 rtl/nexys4_input_ctrl_button_debounce.sv | 93 +++++++++
 rtl/nexys4_input_ctrl.sv | 101 ++++++++++
 tb/tb_nexys4_input_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nexys4_input_ctrl_pkg.sv
// Shared types and constants for the Nexys4 input controller.
package nexys4_input_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARMING,
    PRESSED,
    RELEASING
  } debounce_state_t;

  localparam int unsigned DEBOUNCE_CNT_W = 16;

  localparam int unsigned BTN_CAPTURE = 0;
  localparam int unsigned BTN_NEXT    = 1;

endpackage

// File: rtl/nexys4_input_ctrl_button_debounce.sv
// Two-flop synchroniser plus debounce FSM for one active-high push button.
// Emits a single registered press_event per accepted press.
module button_debounce
  import nexys4_input_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_async,
  output logic pressed_level,
  output logic press_event
);

  localparam logic [DEBOUNCE_CNT_W-1:0] CNT_MAX = DEBOUNCE_CYCLES[DEBOUNCE_CNT_W-1:0];

  logic                      meta_q, meta_d;
  logic                      sync_q, sync_d;
  debounce_state_t           state_q, state_d;
  logic [DEBOUNCE_CNT_W-1:0] cnt_q, cnt_d;
  logic                      event_q, event_d;

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
      event_q <= 1'b0;
    end else begin
      meta_q  <= meta_d;
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      event_q <= event_d;
    end
  end

  // Next-state logic: count consecutive stable samples; counter never exceeds CNT_MAX.
  always_comb begin
    meta_d  = btn_async;
    sync_d  = meta_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    event_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (sync_q) begin
          state_d = ARMING;
          cnt_d   = 16'd1;
        end
      end
      ARMING: begin
        if (cnt_q >= CNT_MAX) begin
          state_d = PRESSED;
          cnt_d   = '0;
          event_d = 1'b1;
        end else if (!sync_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      PRESSED: begin
        if (!sync_q) begin
          state_d = RELEASING;
          cnt_d   = 16'd1;
        end
      end
      RELEASING: begin
        if (sync_q) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q >= CNT_MAX) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign pressed_level = (state_q == PRESSED) || (state_q == RELEASING);
  assign press_event   = event_q;

endmodule

// File: rtl/nexys4_input_ctrl.sv
// Nexys4 input controller: debounced buttons, switch capture with ready/ack
// handshake, next-request flag and sticky overrun flag.
module nexys4_input_ctrl
  import nexys4_input_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50
) (
  input  logic        Clock,
  input  logic        nReset,
  input  logic [15:0] Switches,
  input  logic [1:0]  Buttons,
  output logic [15:0] SwitchData,
  output logic        DataReady,
  input  logic        DataAck,
  output logic        NextRequest,
  input  logic        NextAck,
  output logic        Overrun,
  input  logic        ClearOverrun
);

  logic [1:0] btn_event;
  logic [1:0] btn_level;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_capture (
    .clk          (Clock),
    .rst_n        (nReset),
    .btn_async    (Buttons[BTN_CAPTURE]),
    .pressed_level(btn_level[BTN_CAPTURE]),
    .press_event  (btn_event[BTN_CAPTURE])
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_next (
    .clk          (Clock),
    .rst_n        (nReset),
    .btn_async    (Buttons[BTN_NEXT]),
    .pressed_level(btn_level[BTN_NEXT]),
    .press_event  (btn_event[BTN_NEXT])
  );

  // An event only counts while its debouncer reports the pressed level.
  logic cap_event, next_event;
  assign cap_event  = btn_event[BTN_CAPTURE] & btn_level[BTN_CAPTURE];
  assign next_event = btn_event[BTN_NEXT] & btn_level[BTN_NEXT];

  logic [15:0] sw_meta_q, sw_meta_d;
  logic [15:0] sw_sync_q, sw_sync_d;
  logic [15:0] sw_align_q, sw_align_d;
  logic [15:0] data_q, data_d;
  logic        ready_q, ready_d;
  logic        next_q, next_d;
  logic        ovr_q, ovr_d;

  // Handshake, capture and synchroniser registers.
  always_ff @(posedge Clock) begin
    if (!nReset) begin
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
      sw_align_q <= '0;
      data_q     <= '0;
      ready_q    <= 1'b0;
      next_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      sw_meta_q  <= sw_meta_d;
      sw_sync_q  <= sw_sync_d;
      sw_align_q <= sw_align_d;
      data_q     <= data_d;
      ready_q    <= ready_d;
      next_q     <= next_d;
      ovr_q      <= ovr_d;
    end
  end

  // Capture/flag logic. sw_align_q delays the synchronised switches by one
  // cycle so the value loaded matches the registered press event timing.
  always_comb begin
    logic ovr_set;
    sw_meta_d  = Switches;
    sw_sync_d  = sw_meta_q;
    sw_align_d = sw_sync_q;
    data_d     = data_q;
    ready_d    = ready_q & ~DataAck;
    ovr_set    = 1'b0;
    if (cap_event) begin
      if (!ready_q || DataAck) begin
        data_d  = sw_align_q;
        ready_d = 1'b1;
      end else begin
        ovr_set = 1'b1;
      end
    end
    ovr_d  = ovr_set | (ovr_q & ~ClearOverrun);
    next_d = next_event | (next_q & ~NextAck);
  end

  assign SwitchData  = data_q;
  assign DataReady   = ready_q;
  assign NextRequest = next_q;
  assign Overrun     = ovr_q;

endmodule

// File: tb/tb_nexys4_input_ctrl.sv
// Directed self-checking bench for nexys4_input_ctrl with DEBOUNCE_CYCLES=4.
// A clean press lands DataReady/NextRequest after edge 7 (edge 0 = first
// edge sampling the button high).
module tb_nexys4_input_ctrl;

  logic        Clock = 1'b0;
  logic        nReset;
  logic [15:0] Switches;
  logic [1:0]  Buttons;
  logic [15:0] SwitchData;
  logic        DataReady;
  logic        DataAck;
  logic        NextRequest;
  logic        NextAck;
  logic        Overrun;
  logic        ClearOverrun;

  int vectors    = 0;
  int miscompares = 0;

  nexys4_input_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
    .Clock       (Clock),
    .nReset      (nReset),
    .Switches    (Switches),
    .Buttons     (Buttons),
    .SwitchData  (SwitchData),
    .DataReady   (DataReady),
    .DataAck     (DataAck),
    .NextRequest (NextRequest),
    .NextAck     (NextAck),
    .Overrun     (Overrun),
    .ClearOverrun(ClearOverrun)
  );

  always #5 Clock = ~Clock;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clock);
      #1;
    end
  endtask

  // Raise a button and advance until just after edge `last_edge`.
  task automatic press_to(input int idx, input int last_edge);
    Buttons[idx] = 1'b1;
    tick(last_edge + 1);
  endtask

  task automatic release_all();
    Buttons = 2'b00;
    tick(12);
  endtask

  task automatic test_reset();
    nReset = 1'b0; Switches = 16'hFFFF; Buttons = 2'b00;
    DataAck = 1'b0; NextAck = 1'b0; ClearOverrun = 1'b0;
    tick(2);
    vectors++;
    if ({SwitchData, DataReady, NextRequest, Overrun} !== 19'd0) begin
      miscompares++;
      $display("FAIL reset_outputs got=%h/%b/%b/%b exp=0000/0/0/0", SwitchData, DataReady, NextRequest, Overrun);
    end
    nReset = 1'b1;
    tick(3);
  endtask

  task automatic test_clean_capture();
    Switches = 16'h00A5;
    tick(3);
    press_to(0, 6);
    vectors++;
    if (DataReady !== 1'b0) begin
      miscompares++; $display("FAIL cap_early_ready got=%b exp=0", DataReady);
    end
    tick(1);
    vectors++;
    if (DataReady !== 1'b1) begin
      miscompares++; $display("FAIL cap_ready_edge7 got=%b exp=1", DataReady);
    end
    vectors++;
    if (SwitchData !== 16'h00A5) begin
      miscompares++; $display("FAIL cap_data got=%h exp=00a5", SwitchData);
    end
    DataAck = 1'b1;
    tick(1);
    DataAck = 1'b0;
    vectors++;
    if (DataReady !== 1'b0) begin
      miscompares++; $display("FAIL cap_ack_clear got=%b exp=0", DataReady);
    end
    tick(11);
    vectors++;
    if (DataReady !== 1'b0) begin
      miscompares++; $display("FAIL cap_single_event got=%b exp=0", DataReady);
    end
    release_all();
  endtask

  task automatic test_glitch();
    Switches = 16'h1111;
    Buttons[0] = 1'b1;
    tick(3);
    Buttons[0] = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      vectors++;
      if (DataReady !== 1'b0) begin
        miscompares++; $display("FAIL glitch_ready cyc=%0d got=%b exp=0", i, DataReady);
      end
    end
  endtask

  task automatic test_overrun();
    Switches = 16'h0001;
    tick(3);
    press_to(0, 7);
    vectors++;
    if (DataReady !== 1'b1 || SwitchData !== 16'h0001) begin
      miscompares++; $display("FAIL ovr_first_cap got=%b/%h exp=1/0001", DataReady, SwitchData);
    end
    release_all();
    Switches = 16'h0002;
    tick(3);
    press_to(0, 7);
    vectors++;
    if (SwitchData !== 16'h0001) begin
      miscompares++; $display("FAIL ovr_data_kept got=%h exp=0001", SwitchData);
    end
    vectors++;
    if (Overrun !== 1'b1) begin
      miscompares++; $display("FAIL ovr_set got=%b exp=1", Overrun);
    end
    release_all();
    ClearOverrun = 1'b1;
    tick(1);
    ClearOverrun = 1'b0;
    vectors++;
    if (Overrun !== 1'b0) begin
      miscompares++; $display("FAIL ovr_clear got=%b exp=0", Overrun);
    end
    vectors++;
    if (DataReady !== 1'b1) begin
      miscompares++; $display("FAIL ovr_ready_held got=%b exp=1", DataReady);
    end
  endtask

  task automatic test_ack_collision();
    Switches = 16'h000F;
    tick(3);
    press_to(0, 6);
    DataAck = 1'b1;
    tick(1);
    DataAck = 1'b0;
    vectors++;
    if (DataReady !== 1'b1) begin
      miscompares++; $display("FAIL coll_ready got=%b exp=1", DataReady);
    end
    vectors++;
    if (SwitchData !== 16'h000F) begin
      miscompares++; $display("FAIL coll_data got=%h exp=000f", SwitchData);
    end
    vectors++;
    if (Overrun !== 1'b0) begin
      miscompares++; $display("FAIL coll_overrun got=%b exp=0", Overrun);
    end
    release_all();
    DataAck = 1'b1;
    tick(1);
    DataAck = 1'b0;
    vectors++;
    if (DataReady !== 1'b0) begin
      miscompares++; $display("FAIL coll_final_ack got=%b exp=0", DataReady);
    end
  endtask

  task automatic test_next_request();
    press_to(1, 6);
    vectors++;
    if (NextRequest !== 1'b0) begin
      miscompares++; $display("FAIL next_early got=%b exp=0", NextRequest);
    end
    tick(1);
    vectors++;
    if (NextRequest !== 1'b1) begin
      miscompares++; $display("FAIL next_edge7 got=%b exp=1", NextRequest);
    end
    release_all();
    press_to(1, 7);
    vectors++;
    if (NextRequest !== 1'b1 || Overrun !== 1'b0 || DataReady !== 1'b0) begin
      miscompares++; $display("FAIL next_second got=%b/%b/%b exp=1/0/0", NextRequest, Overrun, DataReady);
    end
    release_all();
    press_to(1, 6);
    NextAck = 1'b1;
    tick(1);
    NextAck = 1'b0;
    vectors++;
    if (NextRequest !== 1'b1) begin
      miscompares++; $display("FAIL next_ack_collision got=%b exp=1", NextRequest);
    end
    release_all();
    NextAck = 1'b1;
    tick(1);
    NextAck = 1'b0;
    vectors++;
    if (NextRequest !== 1'b0) begin
      miscompares++; $display("FAIL next_ack_clear got=%b exp=0", NextRequest);
    end
  endtask

  task automatic test_reset_mid_press();
    Switches = 16'h1234;
    tick(3);
    Buttons = 2'b11;
    tick(8);
    vectors++;
    if (DataReady !== 1'b1 || NextRequest !== 1'b1 || SwitchData !== 16'h1234) begin
      miscompares++; $display("FAIL rst_pre_state got=%b/%b/%h exp=1/1/1234", DataReady, NextRequest, SwitchData);
    end
    release_all();
    Switches = 16'h5555;
    tick(3);
    press_to(0, 7);
    vectors++;
    if (Overrun !== 1'b1 || SwitchData !== 16'h1234) begin
      miscompares++; $display("FAIL rst_pre_overrun got=%b/%h exp=1/1234", Overrun, SwitchData);
    end
    release_all();
    press_to(0, 2);
    nReset = 1'b0;
    tick(1);
    nReset = 1'b1;
    vectors++;
    if ({SwitchData, DataReady, NextRequest, Overrun} !== 19'd0) begin
      miscompares++;
      $display("FAIL rst_mid_outputs got=%h/%b/%b/%b exp=0000/0/0/0", SwitchData, DataReady, NextRequest, Overrun);
    end
    tick(7);
    vectors++;
    if (DataReady !== 1'b0) begin
      miscompares++; $display("FAIL rst_early_capture got=%b exp=0", DataReady);
    end
    tick(1);
    vectors++;
    if (DataReady !== 1'b1 || SwitchData !== 16'h5555) begin
      miscompares++; $display("FAIL rst_capture_edge7 got=%b/%h exp=1/5555", DataReady, SwitchData);
    end
    release_all();
  endtask

  initial begin
    test_reset();
    test_clean_capture();
    test_glitch();
    test_overrun();
    test_ack_collision();
    test_next_request();
    test_reset_mid_press();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
